// File: rtl/load_store_unit.sv
// Memory stage behind the ALU: one data-memory transaction per request over a req/gnt/rvalid bus.
// Formats store lanes/strobes, extracts and extends load data, and flags misaligned/illegal/timeout.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a request; request is checked and latched on accept
// REQ    | mem_req asserted, bus fields held until mem_gnt
// WAIT   | load granted, waiting for mem_rvalid (bounded by TIMEOUT)
// RESP   | one-cycle resp_valid with resp_rdata/resp_err
module load_store_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t        state, state_nxt;
  logic          is_store_q;
  logic [2:0]    funct3_q;
  logic [1:0]    lane_q;
  logic [CW-1:0] cnt;

  logic          acc_err;
  logic          illegal;
  logic          misalign;
  logic [31:0]   st_data;
  logic [3:0]    st_strb;
  logic [31:0]   ld_shift;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic          timed_out;

  assign req_ready  = (state == S_IDLE);
  assign mem_req    = (state == S_REQ);
  assign resp_valid = (state == S_RESP);
  assign timed_out  = (cnt == CW'(TIMEOUT - 1));

  // Request check and store-lane formatting, evaluated on the raw request in IDLE
  always_comb begin
    illegal  = 1'b0;
    misalign = 1'b0;
    st_data  = req_wdata;
    st_strb  = 4'b1111;
    if (req_is_store) begin
      illegal = (req_funct3 > 3'd2);
    end else begin
      illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end
    if (req_funct3[1:0] == 2'b01) begin
      misalign = req_addr[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      misalign = |req_addr[1:0];
    end
    case (req_funct3[1:0])
      2'b00: begin
        st_data = {4{req_wdata[7:0]}};
        st_strb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_data = {2{req_wdata[15:0]}};
        st_strb = 4'b0011 << {req_addr[1], 1'b0};
      end
      default: begin
        st_data = req_wdata;
        st_strb = 4'b1111;
      end
    endcase
    acc_err = illegal || misalign;
  end

  always_comb begin
    ld_shift = mem_rdata >> {lane_q, 3'b000};
    ld_half  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'd0:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_shift[7:0]};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt = acc_err ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_nxt = is_store_q ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid || timed_out) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      lane_q     <= 2'd0;
      cnt        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            lane_q     <= req_addr[1:0];
            resp_err   <= acc_err;
            resp_rdata <= 32'd0;
            // Rejected requests never touch the bus, so leave its fields alone
            if (!acc_err) begin
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_we    <= req_is_store;
              mem_wdata <= st_data;
              mem_wstrb <= req_is_store ? st_strb : 4'b0000;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            cnt       <= '0;
          end
        end
        S_WAIT: begin
          // rvalid on the timeout cycle still delivers data
          if (mem_rvalid) begin
            resp_rdata <= ld_data;
            resp_err   <= 1'b0;
          end else if (timed_out) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit: each request pushes its expected response and cycle,
// a monitor pops and compares on resp_valid; bus fields are checked while the request is pending.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;
  localparam int NO_RV   = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   resp_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic err_model(input logic st, input logic [2:0] f3, input logic [31:0] a);
    logic e;
    e = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) e = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a[1:0] +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      exp_t e;
      resp_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_cycle", cyc, e.cyc);
        check("ready_in_resp", {31'd0, req_ready}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < TIMEOUT + 40; i++) begin
      @(negedge clk);
      #1;
      if (req_ready && exp_q.size() == 0) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
    exp_q.delete();
  endtask

  // gd: cycles in REQ before gnt; rv: cycles in WAIT before rvalid (>=TIMEOUT: never)
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rword,
                         input int gd, input int rv, input logic spur);
    exp_t        e;
    logic        err;
    logic [31:0] ew;
    logic [3:0]  es;
    err = err_model(st, f3, a);
    case (f3[1:0])
      2'b00:   begin ew = {4{wd[7:0]}};  es = 4'b0001 << a[1:0]; end
      2'b01:   begin ew = {2{wd[15:0]}}; es = a[1] ? 4'b1100 : 4'b0011; end
      default: begin ew = wd;            es = 4'b1111; end
    endcase
    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    e.err   = err || (!st && rv >= TIMEOUT);
    e.rdata = (e.err || st) ? 32'd0 : ld_model(f3, a, rword);
    if (err)             e.cyc = cyc + 1;
    else if (st)         e.cyc = cyc + 2 + gd;
    else if (rv >= TIMEOUT) e.cyc = cyc + 2 + gd + TIMEOUT;
    else                 e.cyc = cyc + 3 + gd + rv;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    if (err) begin
      check("no_req_on_err", {31'd0, mem_req}, 32'd0);
    end else begin
      check("mem_req", {31'd0, mem_req}, 32'd1);
      check("mem_we", {31'd0, mem_we}, {31'd0, st});
      check("mem_addr", mem_addr, {a[31:2], 2'b00});
      if (st) begin
        check("mem_wdata", mem_wdata, ew);
        check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, es});
      end else begin
        check("wstrb_read", {28'd0, mem_wstrb}, 32'd0);
      end
      repeat (gd) begin
        mem_rvalid = spur; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
      end
      mem_rvalid = 1'b0; mem_gnt = 1'b1;
      check("req_held", {31'd0, mem_req}, 32'd1);
      check("addr_held", mem_addr, {a[31:2], 2'b00});
      @(negedge clk);
      mem_gnt = 1'b0;
      if (!st && rv < TIMEOUT) begin
        repeat (rv) @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = rword;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
    end
    wait_idle();
  endtask

  initial begin
    int rc;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    rst_n = 1'b1;

    //      st    f3    addr          wdata         rword         gd rv     spur
    run_txn(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0,        2, 0,     1'b0);
    run_txn(1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'd0,        0, 0,     1'b0);
    run_txn(1'b1, 3'd1, 32'h0000_0102, 32'h1111_BEEF, 32'd0,        1, 0,     1'b0);
    run_txn(1'b1, 3'd0, 32'h0000_0101, 32'h0000_003C, 32'd0,        0, 0,     1'b0);
    run_txn(1'b0, 3'd0, 32'h0000_0201, 32'd0,         32'h1234_80FF, 0, 0,    1'b0);
    run_txn(1'b0, 3'd4, 32'h0000_0201, 32'd0,         32'h1234_80FF, 2, 2,    1'b1);
    run_txn(1'b0, 3'd5, 32'h0000_0202, 32'd0,         32'h1234_80FF, 1, 1,    1'b0);
    run_txn(1'b0, 3'd1, 32'h0000_0200, 32'd0,         32'h1234_80FF, 0, 3,    1'b0);
    run_txn(1'b0, 3'd0, 32'h0000_0203, 32'd0,         32'h7F00_0000, 0, 0,    1'b0);
    run_txn(1'b0, 3'd2, 32'h0000_0104, 32'd0,         32'hCAFE_F00D, 3, 1,    1'b1);
    run_txn(1'b0, 3'd2, 32'h0000_0102, 32'd0,         32'd0,        0, 0,     1'b0);
    run_txn(1'b0, 3'd3, 32'h0000_0100, 32'd0,         32'd0,        0, 0,     1'b0);
    run_txn(1'b0, 3'd7, 32'h0000_0100, 32'd0,         32'd0,        0, 0,     1'b0);
    run_txn(1'b0, 3'd5, 32'h0000_0203, 32'd0,         32'd0,        0, 0,     1'b0);
    run_txn(1'b1, 3'd1, 32'h0000_0101, 32'd0,         32'd0,        0, 0,     1'b0);
    run_txn(1'b1, 3'd3, 32'h0000_0100, 32'd0,         32'd0,        0, 0,     1'b0);
    run_txn(1'b0, 3'd2, 32'h0000_0300, 32'd0,         32'd0,        1, NO_RV, 1'b0);
    run_txn(1'b0, 3'd2, 32'h0000_0304, 32'd0,         32'h5555_AAAA, 0, TIMEOUT - 1, 1'b0);

    // Reset while the bus request is pending
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0400;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_pre_req", {31'd0, mem_req}, 32'd1);
    rc = resp_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("rst_drops_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready_after", {31'd0, req_ready}, 32'd1);
    check("rst_no_resp", resp_cnt, rc);

    run_txn(1'b1, 3'd1, 32'h0000_0500, 32'h0000_1234, 32'd0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks done expected completion", n_chk);
    $fatal(1);
  end

endmodule
